// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - two-master round-robin system bus arbiter with access watchdog
module bus_arbiter_rr #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_m0_request,
  input  logic        i_m0_rw,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_wdata,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_ready,
  input  logic        i_m1_request,
  input  logic        i_m1_rw,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_wdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic        o_timeout,
  output logic        o_grant
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             grant;
  logic             last_owner;
  logic [CNT_W-1:0] wdog;

  logic busy;
  logic owner_request;
  logic wd_hit;
  logic done;
  logic abort;

  assign busy          = (state == S_BUSY);
  assign owner_request = grant ? i_m1_request : i_m0_request;
  // A real ready in the last watchdog cycle still wins over the forced completion.
  assign wd_hit        = busy && owner_request && !i_bus_ready && (wdog == WD_MAX);
  assign done          = busy && owner_request && (i_bus_ready || wd_hit);
  assign abort         = busy && !owner_request;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_owner <= 1'b1;
      wdog       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_m0_request || i_m1_request) begin
            state <= S_BUSY;
            grant <= (i_m0_request && i_m1_request) ? ~last_owner : i_m1_request;
          end
        end
        S_BUSY: begin
          if (done || abort) begin
            state      <= S_RELEASE;
            last_owner <= grant;
            wdog       <= '0;
          end else if (wdog != WD_MAX) begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign o_bus_request = busy;
  assign o_bus_rw      = grant ? i_m1_rw      : i_m0_rw;
  assign o_bus_address = grant ? i_m1_address : i_m0_address;
  assign o_bus_wdata   = grant ? i_m1_wdata   : i_m0_wdata;

  assign o_m0_ready = done && !grant;
  assign o_m1_ready = done && grant;
  assign o_m0_rdata = (busy && !grant && !wd_hit) ? i_bus_rdata : 32'd0;
  assign o_m1_rdata = (busy && grant && !wd_hit) ? i_bus_rdata : 32'd0;
  assign o_timeout  = wd_hit;
  assign o_grant    = grant;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr
module tb_bus_arbiter_rr;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_m0_request, i_m0_rw, i_m1_request, i_m1_rw;
  logic [31:0] i_m0_address, i_m0_wdata, i_m1_address, i_m1_wdata;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_m0_ready, o_m1_ready;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address, o_bus_wdata, i_bus_rdata;
  logic        i_bus_ready, o_timeout, o_grant;

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  bus_arbiter_rr #(.TIMEOUT(16), .CNT_W(5)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_m0_request(i_m0_request), .i_m0_rw(i_m0_rw), .i_m0_address(i_m0_address),
    .i_m0_wdata(i_m0_wdata), .o_m0_rdata(o_m0_rdata), .o_m0_ready(o_m0_ready),
    .i_m1_request(i_m1_request), .i_m1_rw(i_m1_rw), .i_m1_address(i_m1_address),
    .i_m1_wdata(i_m1_wdata), .o_m1_rdata(o_m1_rdata), .o_m1_ready(o_m1_ready),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
    .o_bus_wdata(o_bus_wdata), .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready),
    .o_timeout(o_timeout), .o_grant(o_grant)
  );

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic apply_reset;
    i_reset = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
  endtask

  task automatic test_reset;
    i_m0_request = 0; i_m0_rw = 0; i_m0_address = 0; i_m0_wdata = 0;
    i_m1_request = 0; i_m1_rw = 0; i_m1_address = 0; i_m1_wdata = 0;
    i_bus_rdata = 0; i_bus_ready = 0;
    i_reset = 1'b0;
    tick();
    checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL rst_busreq got %0b exp 0", o_bus_request); end
    checks++; if (o_grant !== 1'b0) begin errors++; $display("FAIL rst_grant got %0b exp 0", o_grant); end
    checks++; if ({o_m0_ready, o_m1_ready, o_timeout} !== 3'b000) begin errors++; $display("FAIL rst_ready got %b exp 000", {o_m0_ready, o_m1_ready, o_timeout}); end
    tick();
    i_reset = 1'b1;
  endtask

  task automatic test_single_read;
    i_m0_request = 1; i_m0_rw = 0; i_m0_address = 32'h0000_0100;
    #1;
    checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL t1_latency got %0b exp 0", o_bus_request); end
    tick();
    checks++; if (o_bus_request !== 1'b1) begin errors++; $display("FAIL t1_busreq got %0b exp 1", o_bus_request); end
    checks++; if (o_bus_address !== 32'h0000_0100) begin errors++; $display("FAIL t1_addr got %h exp 00000100", o_bus_address); end
    checks++; if (o_m0_ready !== 1'b0) begin errors++; $display("FAIL t1_early_ready got %0b exp 0", o_m0_ready); end
    tick();
    i_bus_ready = 1; i_bus_rdata = 32'hCAFE_0001;
    #1;
    checks++; if (o_m0_ready !== 1'b1) begin errors++; $display("FAIL t1_ready got %0b exp 1", o_m0_ready); end
    checks++; if (o_m0_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL t1_rdata got %h exp cafe0001", o_m0_rdata); end
    checks++; if (o_m1_rdata !== 32'd0 || o_m1_ready !== 1'b0) begin errors++; $display("FAIL t1_m1_quiet got %h/%0b exp 0/0", o_m1_rdata, o_m1_ready); end
    tick();
    i_m0_request = 0; i_bus_ready = 0;
    #1;
    checks++; if (o_bus_request !== 1'b0 || o_m0_ready !== 1'b0) begin errors++; $display("FAIL t1_release got %0b/%0b exp 0/0", o_bus_request, o_m0_ready); end
    checks++; if (o_grant !== 1'b0) begin errors++; $display("FAIL t1_grant got %0b exp 0", o_grant); end
    tick();
    checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL t1_idle got %0b exp 0", o_bus_request); end
  endtask

  task automatic test_alternation;
    apply_reset();
    i_m0_request = 1; i_m1_request = 1;
    i_m0_address = 32'h0000_1000; i_m1_address = 32'h0000_2000;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (o_grant !== 1'(i % 2)) begin errors++; $display("FAIL t2_grant[%0d] got %0b exp %0b", i, o_grant, 1'(i % 2)); end
      checks++; if (o_bus_address !== ((i % 2) ? 32'h0000_2000 : 32'h0000_1000)) begin errors++; $display("FAIL t2_addr[%0d] got %h", i, o_bus_address); end
      i_bus_ready = 1;
      #1;
      checks++; if ({o_m1_ready, o_m0_ready} !== ((i % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL t2_ready[%0d] got %b exp %b", i, {o_m1_ready, o_m0_ready}, ((i % 2) ? 2'b10 : 2'b01)); end
      tick();
      i_bus_ready = 0;
      if (i == 7) begin i_m0_request = 0; i_m1_request = 0; end
      #1;
      checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL t2_release[%0d] got %0b exp 0", i, o_bus_request); end
      tick();
    end
  endtask

  task automatic test_write_no_preempt;
    i_m1_request = 1; i_m1_rw = 1; i_m1_address = 32'h2000_0000; i_m1_wdata = 32'hDEAD_BEEF;
    tick();
    checks++; if ({o_grant, o_bus_rw} !== 2'b11) begin errors++; $display("FAIL t3_grant_rw got %b exp 11", {o_grant, o_bus_rw}); end
    checks++; if (o_bus_address !== 32'h2000_0000 || o_bus_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t3_bus got %h/%h exp 20000000/deadbeef", o_bus_address, o_bus_wdata); end
    i_m0_request = 1; i_m0_rw = 0; i_m0_address = 32'h3000_0000;
    tick();
    checks++; if (o_bus_address !== 32'h2000_0000 || o_bus_wdata !== 32'hDEAD_BEEF || o_bus_rw !== 1'b1) begin errors++; $display("FAIL t3_hold got %h/%h/%0b", o_bus_address, o_bus_wdata, o_bus_rw); end
    checks++; if (o_m0_ready !== 1'b0 || o_grant !== 1'b1) begin errors++; $display("FAIL t3_nopreempt got %0b/%0b exp 0/1", o_m0_ready, o_grant); end
    i_bus_ready = 1;
    #1;
    checks++; if ({o_m1_ready, o_m0_ready} !== 2'b10) begin errors++; $display("FAIL t3_ready got %b exp 10", {o_m1_ready, o_m0_ready}); end
    tick();
    i_m1_request = 0; i_m1_rw = 0; i_bus_ready = 0;
    tick();
    checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL t3_idle got %0b exp 0", o_bus_request); end
    tick();
    checks++; if (o_grant !== 1'b0 || o_bus_address !== 32'h3000_0000) begin errors++; $display("FAIL t3_m0_next got %0b/%h exp 0/30000000", o_grant, o_bus_address); end
    i_bus_ready = 1;
    tick();
    i_m0_request = 0; i_bus_ready = 0;
    tick();
  endtask

  task automatic test_timeout;
    i_m0_request = 1; i_m0_address = 32'h6000_0000; i_bus_rdata = 32'h1234_5678;
    tick();
    for (int k = 1; k <= 15; k++) begin
      checks++; if (o_timeout !== 1'b0 || o_m0_ready !== 1'b0) begin errors++; $display("FAIL t4_early[%0d] got %0b/%0b exp 0/0", k, o_timeout, o_m0_ready); end
      tick();
    end
    checks++; if (o_timeout !== 1'b1 || o_m0_ready !== 1'b1) begin errors++; $display("FAIL t4_pulse got %0b/%0b exp 1/1", o_timeout, o_m0_ready); end
    checks++; if (o_m0_rdata !== 32'd0) begin errors++; $display("FAIL t4_rdata got %h exp 0", o_m0_rdata); end
    tick();
    i_m0_request = 0; i_m1_request = 1;
    #1;
    checks++; if (o_timeout !== 1'b0 || o_bus_request !== 1'b0) begin errors++; $display("FAIL t4_release got %0b/%0b exp 0/0", o_timeout, o_bus_request); end
    tick();
    tick();
    checks++; if (o_grant !== 1'b1 || o_bus_request !== 1'b1) begin errors++; $display("FAIL t4_next got %0b/%0b exp 1/1", o_grant, o_bus_request); end
    i_bus_ready = 1;
    #1;
    checks++; if (o_m1_ready !== 1'b1 || o_timeout !== 1'b0) begin errors++; $display("FAIL t4_next_ready got %0b/%0b exp 1/0", o_m1_ready, o_timeout); end
    tick();
    i_m1_request = 0; i_bus_ready = 0;
    tick();
  endtask

  task automatic test_async_reset;
    i_m0_request = 1;
    tick();
    i_bus_ready = 1;
    tick();
    i_m0_request = 0; i_bus_ready = 0;
    tick();
    i_m1_request = 1;
    tick();
    i_bus_ready = 1;
    #1;
    checks++; if (o_m1_ready !== 1'b1) begin errors++; $display("FAIL t5_pre got %0b exp 1", o_m1_ready); end
    #1;
    i_reset = 0;
    #1;
    checks++; if (o_bus_request !== 1'b0 || o_m1_ready !== 1'b0 || o_m0_ready !== 1'b0) begin errors++; $display("FAIL t5_abort got %0b/%0b/%0b exp 0/0/0", o_bus_request, o_m1_ready, o_m0_ready); end
    checks++; if (o_grant !== 1'b0) begin errors++; $display("FAIL t5_grant_rst got %0b exp 0", o_grant); end
    i_bus_ready = 0; i_m1_request = 0;
    tick();
    i_reset = 1;
    i_m0_request = 1; i_m1_request = 1;
    tick();
    checks++; if (o_grant !== 1'b0 || o_bus_request !== 1'b1) begin errors++; $display("FAIL t5_first got %0b/%0b exp 0/1", o_grant, o_bus_request); end
    i_bus_ready = 1;
    tick();
    i_m0_request = 0; i_m1_request = 0; i_bus_ready = 0;
    tick();
  endtask

  task automatic test_drop_request;
    i_m1_request = 1;
    tick();
    checks++; if (o_grant !== 1'b1) begin errors++; $display("FAIL t6_grant got %0b exp 1", o_grant); end
    i_m1_request = 0;
    #1;
    checks++; if (o_m1_ready !== 1'b0) begin errors++; $display("FAIL t6_noready got %0b exp 0", o_m1_ready); end
    tick();
    i_bus_ready = 1;
    #1;
    checks++; if (o_bus_request !== 1'b0 || o_m1_ready !== 1'b0 || o_m0_ready !== 1'b0) begin errors++; $display("FAIL t6_release got %0b/%0b/%0b exp 0/0/0", o_bus_request, o_m1_ready, o_m0_ready); end
    i_bus_ready = 0;
    tick();
    checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL t6_idle got %0b exp 0", o_bus_request); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternation();
    test_write_no_preempt();
    test_timeout();
    test_async_reset();
    test_drop_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
